laser_host: RTL and testbench

Host-side driver for the LASER two-circle coverage engine: holds a 40-point image loaded over a simple write port, releases LASER from reset and streams the points on X/Y with exact cycle alignment, waits for DONE, then captures the two centres. It also independently scores the result, counting image points inside the union of the two radius-4 circles, so firmware and the bench get a self-checked result. It sits between the system register interface and the LASER instance, and owns LASER's RST.

---
 rtl/laser_pkg.sv | 31 +++
 rtl/laser_host_if.sv | 28 ++
 rtl/laser_cover_check.sv | 30 +++
 rtl/laser_host.sv | 178 +++++++++++++++++
 tb/tb_laser_host.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
// laser_pkg: definitions shared by the LASER host and by LASER-side checkers.
//   NUM_POINTS  points per image; the LASER protocol fixes this at 40
//   RADIUS_SQ   squared coverage radius (radius 4)
//   IDX_W       width of a point index
//   point_t     one image point, 4-bit x and 4-bit y
//   host_state_t  host sequencing states
//   abs_diff    absolute difference of two 4-bit coordinates
package laser_pkg;

  localparam int NUM_POINTS = 40;
  localparam int RADIUS_SQ  = 16;
  localparam int IDX_W      = 6;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } point_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT,
    ST_SCORE,
    ST_REPORT
  } host_state_t;

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/laser_host_if.sv
// laser_host_if: link between the host driver and one LASER instance.
//   L_RST   active-high reset to LASER (host drives)
//   X, Y    point stream to LASER (host drives)
//   DONE    LASER completion pulse
//   C1X, C1Y, C2X, C2Y  LASER result centres, valid in the DONE cycle
// Modports: master = host side, slave = LASER side.
interface laser_host_if;

  logic       L_RST;
  logic [3:0] X;
  logic [3:0] Y;
  logic       DONE;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;

  modport master (
    output L_RST, X, Y,
    input  DONE, C1X, C1Y, C2X, C2Y
  );

  modport slave (
    input  L_RST, X, Y,
    output DONE, C1X, C1Y, C2X, C2Y
  );

endinterface

// File: rtl/laser_cover_check.sv
// laser_cover_check: combinational coverage test of one point against two
// radius-4 circles.
//   pt       point under test
//   c1, c2   circle centres
//   covered  1 when the point lies inside or on either circle
module laser_cover_check
  import laser_pkg::*;
(
  input  point_t pt,
  input  point_t c1,
  input  point_t c2,
  output logic   covered
);

  logic [3:0] dx1, dy1, dx2, dy2;
  logic [8:0] d1_sq, d2_sq;

  // Differences stay 4-bit unsigned; the squares are summed in 9 bits so
  // the worst case 15^2 + 15^2 = 450 cannot wrap.
  always_comb begin
    dx1     = abs_diff(pt.x, c1.x);
    dy1     = abs_diff(pt.y, c1.y);
    dx2     = abs_diff(pt.x, c2.x);
    dy2     = abs_diff(pt.y, c2.y);
    d1_sq   = 9'(dx1) * 9'(dx1) + 9'(dy1) * 9'(dy1);
    d2_sq   = 9'(dx2) * 9'(dx2) + 9'(dy2) * 9'(dy2);
    covered = (d1_sq <= 9'(RADIUS_SQ)) || (d2_sq <= 9'(RADIUS_SQ));
  end

endmodule

// File: rtl/laser_host.sv
// laser_host: host-side driver for the LASER two-circle coverage engine.
// Holds a 40-point image, streams it to LASER with LASER released from reset,
// waits for DONE, captures the two centres and scores how many image points
// fall inside the union of the two circles.
//   CLK, RST_N        clock (rising edge) and asynchronous active-low reset
//   WR_EN, WR_ADDR, WR_X, WR_Y  image write port, honoured only in IDLE
//   START             run request, honoured only in IDLE
//   BUSY              high while a run is in progress
//   laser             master side of laser_host_if (L_RST, X, Y, DONE, centres)
//   RES_C             captured {C1X,C1Y,C2X,C2Y}
//   SCORE             covered-point count, 0..40
//   RESULT_VALID      one-cycle pulse when RES_C/SCORE are final
//   TIMEOUT           sticky watchdog abort flag
// Build option: define LASER_HOST_TIMEOUT_EN to compile in the WAIT watchdog
// (limit TIMEOUT_CYCLES); without it WAIT lasts until DONE and TIMEOUT is 0.
module laser_host #(
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [5:0]        WR_ADDR,
  input  logic [3:0]        WR_X,
  input  logic [3:0]        WR_Y,
  input  logic              START,
  output logic              BUSY,
  laser_host_if.master      laser,
  output logic [15:0]       RES_C,
  output logic [5:0]        SCORE,
  output logic              RESULT_VALID,
  output logic              TIMEOUT
);

  import laser_pkg::*;

  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_POINTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_POINTS - 1);

  host_state_t      state;
  point_t           mem [NUM_POINTS];
  logic [IDX_W-1:0] idx;
  logic [5:0]       acc;
  logic             wr_ok;
  point_t           wr_pt;
  point_t           first_pt;
  point_t           cur_pt;
  point_t           cen1;
  point_t           cen2;
  logic             covered;

`ifdef LASER_HOST_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`else
  // Watchdog not built: the limit has no effect and the flag stays low.
  assign TIMEOUT = (TIMEOUT_CYCLES < 0);
`endif

  assign wr_ok = WR_EN && (state == ST_IDLE) && (WR_ADDR < IDX_W'(NUM_POINTS));
  assign wr_pt = '{x: WR_X, y: WR_Y};

  // A write to point 0 on the START edge must reach the stream's first cycle,
  // so the incoming data bypasses the memory for that one read.
  assign first_pt = (wr_ok && (WR_ADDR == '0)) ? wr_pt : mem[0];
  assign cur_pt   = mem[idx];
  assign cen1     = '{x: RES_C[15:12], y: RES_C[11:8]};
  assign cen2     = '{x: RES_C[7:4],   y: RES_C[3:0]};

  laser_cover_check u_cover (
    .pt      (cur_pt),
    .c1      (cen1),
    .c2      (cen2),
    .covered (covered)
  );

  // Image store; deliberately not reset so an image survives RST_N.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[WR_ADDR] <= wr_pt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      laser.L_RST  <= 1'b1;
      laser.X      <= '0;
      laser.Y      <= '0;
      BUSY         <= 1'b0;
      RES_C        <= '0;
      SCORE        <= '0;
      RESULT_VALID <= 1'b0;
      idx          <= '0;
      acc          <= '0;
`ifdef LASER_HOST_TIMEOUT_EN
      TIMEOUT      <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          laser.L_RST  <= 1'b1;
          laser.X      <= '0;
          laser.Y      <= '0;
          RESULT_VALID <= 1'b0;
          if (START) begin
            state       <= ST_STREAM;
            BUSY        <= 1'b1;
            laser.L_RST <= 1'b0;
            laser.X     <= first_pt.x;
            laser.Y     <= first_pt.y;
            idx         <= IDX_W'(1);
`ifdef LASER_HOST_TIMEOUT_EN
            TIMEOUT     <= 1'b0;
`endif
          end
        end

        // idx names the point driven in the next cycle; point 0 went out on entry.
        ST_STREAM: begin
          if (idx == IDX_END) begin
            state   <= ST_WAIT;
            laser.X <= '0;
            laser.Y <= '0;
            idx     <= '0;
`ifdef LASER_HOST_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            laser.X <= cur_pt.x;
            laser.Y <= cur_pt.y;
            idx     <= idx + IDX_W'(1);
          end
        end

        ST_WAIT: begin
          if (laser.DONE) begin
            state       <= ST_SCORE;
            laser.L_RST <= 1'b1;
            RES_C       <= {laser.C1X, laser.C1Y, laser.C2X, laser.C2Y};
            acc         <= '0;
            idx         <= '0;
          end
`ifdef LASER_HOST_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            state        <= ST_REPORT;
            laser.L_RST  <= 1'b1;
            TIMEOUT      <= 1'b1;
            SCORE        <= '0;
            RESULT_VALID <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end

        // The last point's coverage is folded straight into SCORE.
        ST_SCORE: begin
          if (idx == IDX_LAST) begin
            state        <= ST_REPORT;
            SCORE        <= acc + {5'd0, covered};
            RESULT_VALID <= 1'b1;
          end else begin
            acc <= acc + {5'd0, covered};
            idx <= idx + IDX_W'(1);
          end
        end

        ST_REPORT: begin
          state        <= ST_IDLE;
          RESULT_VALID <= 1'b0;
          BUSY         <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// tb_laser_host: self-checking bench for laser_host. Keeps its own copy of the
// image and scores it with plain integer geometry; LASER is modelled by
// driving DONE and the centres from the bench.
module tb_laser_host;

  localparam int TB_TIMEOUT = 100;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_x;
  logic [3:0]  wr_y;
  logic        start;
  logic        busy;
  logic [15:0] res_c;
  logic [5:0]  score;
  logic        result_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [3:0]  img_x [40];
  logic [3:0]  img_y [40];
  logic [15:0] last_res;

  laser_host_if lif();

  laser_host #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .WR_EN        (wr_en),
    .WR_ADDR      (wr_addr),
    .WR_X         (wr_x),
    .WR_Y         (wr_y),
    .START        (start),
    .BUSY         (busy),
    .laser        (lif.master),
    .RES_C        (res_c),
    .SCORE        (score),
    .RESULT_VALID (result_valid),
    .TIMEOUT      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design stalls somewhere unbounded.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] stopped");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference scorer: Euclidean distance squared with ordinary integers.
  function automatic int model_score(input int c1x, input int c1y, input int c2x, input int c2y);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      int ax = int'(img_x[i]) - c1x;
      int ay = int'(img_y[i]) - c1y;
      int bx = int'(img_x[i]) - c2x;
      int by = int'(img_y[i]) - c2y;
      if ((ax * ax + ay * ay <= 16) || (bx * bx + by * by <= 16)) n++;
    end
    return n;
  endfunction

  task automatic write_point(input int i, input logic [3:0] x, input logic [3:0] y);
    wr_en = 1'b1; wr_addr = 6'(i); wr_x = x; wr_y = y;
    tick();
    wr_en = 1'b0;
    img_x[i] = x; img_y[i] = y;
  endtask

  task automatic drive_noise();
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 6'($urandom_range(0, 63));
    wr_x    = 4'($urandom);
    wr_y    = 4'($urandom);
  endtask

  task automatic clear_noise();
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  // One full run: START (optionally with a same-edge write), stream check,
  // DONE at cycle done_at after the START edge, score and report check.
  task automatic run_image(input logic [3:0] c1x, input logic [3:0] c1y,
                           input logic [3:0] c2x, input logic [3:0] c2y,
                           input int done_at, input bit noise,
                           input bit co_wr, input logic [5:0] co_addr,
                           input logic [3:0] co_x, input logic [3:0] co_y);
    int cyc;
    int exp_score;
    int pulses;
    bit wait_bad;
    logic [15:0] exp_res;
    if (co_wr) begin
      wr_en = 1'b1; wr_addr = co_addr; wr_x = co_x; wr_y = co_y;
      if (co_addr < 40) begin img_x[co_addr] = co_x; img_y[co_addr] = co_y; end
    end
    start = 1'b1;
    tick();
    clear_noise();
    cyc = 1;
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_flags: BUSY=%b TIMEOUT=%b, expected BUSY=1 TIMEOUT=0", busy, timeout);
    end
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin tick(); cyc++; end
      if (noise) begin
        drive_noise();
        lif.DONE = 1'($urandom_range(0, 1));
        lif.C1X = 4'($urandom); lif.C1Y = 4'($urandom);
        lif.C2X = 4'($urandom); lif.C2Y = 4'($urandom);
      end
      checks++;
      if (lif.L_RST !== 1'b0 || lif.X !== img_x[k] || lif.Y !== img_y[k]) begin
        errors++;
        $display("[TB] FAIL stream[%0d]: L_RST=%b X=%0d Y=%0d, expected L_RST=0 X=%0d Y=%0d",
                 k, lif.L_RST, lif.X, lif.Y, img_x[k], img_y[k]);
      end
    end
    tick(); cyc++;
    lif.DONE = 1'b0;
    checks++;
    if (lif.L_RST !== 1'b0 || lif.X !== 4'd0 || lif.Y !== 4'd0) begin
      errors++;
      $display("[TB] FAIL wait_entry: L_RST=%b X=%0d Y=%0d, expected 0 0 0", lif.L_RST, lif.X, lif.Y);
    end
    wait_bad = 1'b0;
    while (cyc < done_at) begin
      tick(); cyc++;
      if (noise) drive_noise();
      if (lif.L_RST !== 1'b0 || result_valid !== 1'b0) wait_bad = 1'b1;
    end
    checks++;
    if (wait_bad) begin
      errors++;
      $display("[TB] FAIL wait_hold: L_RST or RESULT_VALID changed in WAIT, expected 0/0");
    end
    lif.DONE = 1'b1;
    lif.C1X = c1x; lif.C1Y = c1y; lif.C2X = c2x; lif.C2Y = c2y;
    exp_res   = {c1x, c1y, c2x, c2y};
    exp_score = model_score(int'(c1x), int'(c1y), int'(c2x), int'(c2y));
    tick();
    lif.DONE = 1'b0;
    lif.C1X = 4'($urandom); lif.C1Y = 4'($urandom);
    lif.C2X = 4'($urandom); lif.C2Y = 4'($urandom);
    checks++;
    if (res_c !== exp_res || lif.L_RST !== 1'b1) begin
      errors++;
      $display("[TB] FAIL capture: RES_C=%h L_RST=%b, expected RES_C=%h L_RST=1", res_c, lif.L_RST, exp_res);
    end
    pulses = 0;
    for (int j = 1; j <= 40; j++) begin
      if (result_valid === 1'b1) pulses++;
      if (noise && j < 40) drive_noise(); else clear_noise();
      tick();
    end
    checks++;
    if (result_valid !== 1'b1 || pulses != 0 || score !== 6'(exp_score) || res_c !== exp_res) begin
      errors++;
      $display("[TB] FAIL report: RV=%b early_pulses=%0d SCORE=%0d RES_C=%h, expected RV=1 0 SCORE=%0d RES_C=%h",
               result_valid, pulses, score, res_c, exp_score, exp_res);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || lif.L_RST !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_idle: RV=%b BUSY=%b L_RST=%b TIMEOUT=%b, expected 0 0 1 0",
               result_valid, busy, lif.L_RST, timeout);
    end
    last_res = exp_res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (lif.L_RST !== 1'b1 || busy !== 1'b0 || lif.X !== 4'd0 || lif.Y !== 4'd0 ||
        score !== 6'd0 || result_valid !== 1'b0 || res_c !== 16'd0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: L_RST=%b BUSY=%b X=%0d Y=%0d SCORE=%0d RV=%b RES_C=%h TO=%b, expected 1 0 0 0 0 0 0000 0",
               lif.L_RST, busy, lif.X, lif.Y, score, result_valid, res_c, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (lif.L_RST !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: L_RST=%b BUSY=%b, expected 1 0", lif.L_RST, busy);
    end
    last_res = 16'd0;
  endtask

  task automatic test_all_sevens();
    for (int i = 0; i < 40; i++) write_point(i, 4'd7, 4'd7);
    run_image(4'd7, 4'd7, 4'd0, 4'd0, 200, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
  endtask

  task automatic test_radius_boundary();
    for (int i = 0; i < 20; i++) write_point(i, 4'd0, 4'd0);
    for (int i = 20; i < 40; i++) write_point(i, 4'd15, 4'd15);
    run_image(4'd2, 4'd2, 4'd12, 4'd12, 60, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
    run_image(4'd2, 4'd2, 4'd12, 4'd13, 45, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
  endtask

  task automatic test_stream_order();
    for (int i = 0; i < 40; i++) write_point(i, 4'(i % 16), 4'(i / 16));
    run_image(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 80, 1'b1, 1'b0, 6'd0, 4'd0, 4'd0);
    // Second run with quiet inputs shows the noisy writes left the image alone.
    run_image(4'd3, 4'd1, 4'd10, 4'd1, 42, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
  endtask

  task automatic test_write_with_start();
    run_image(4'd5, 4'd5, 4'd9, 4'd0, 50, 1'b0, 1'b1, 6'd0, 4'd14, 4'd3);
    run_image(4'd5, 4'd5, 4'd9, 4'd0, 50, 1'b0, 1'b1, 6'd5, 4'd2, 4'd11);
    run_image(4'd5, 4'd5, 4'd9, 4'd0, 50, 1'b0, 1'b1, 6'd45, 4'd1, 4'd1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) write_point(i, 4'($urandom), 4'($urandom));
      run_image(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                int'($urandom_range(42, 120)), 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
    end
  endtask

  task automatic test_reset_midstream();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (lif.L_RST !== 1'b1 || busy !== 1'b0 || lif.X !== 4'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: L_RST=%b BUSY=%b X=%0d, expected 1 0 0", lif.L_RST, busy, lif.X);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    last_res = 16'd0;
    run_image(4'd1, 4'd1, 4'd8, 4'd8, 70, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
  endtask

`ifdef LASER_HOST_TIMEOUT_EN
  task automatic test_watchdog();
    int cyc;
    int pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    pulses = 0;
    while (result_valid !== 1'b1 && cyc < 41 + TB_TIMEOUT + 50) begin
      tick(); cyc++;
    end
    if (result_valid === 1'b1) pulses++;
    checks++;
    if (cyc != 41 + TB_TIMEOUT || timeout !== 1'b1 || score !== 6'd0 ||
        lif.L_RST !== 1'b1 || res_c !== last_res) begin
      errors++;
      $display("[TB] FAIL watchdog_report: cycle=%0d TO=%b SCORE=%0d L_RST=%b RES_C=%h, expected %0d 1 0 1 %h",
               cyc, timeout, score, lif.L_RST, res_c, 41 + TB_TIMEOUT, last_res);
    end
    repeat (3) begin
      tick();
      if (result_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || busy !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL watchdog_idle: pulses=%0d BUSY=%b TO=%b, expected 1 0 1", pulses, busy, timeout);
    end
    run_image(4'd4, 4'd4, 4'd11, 4'd11, 90, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
  endtask
`endif

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0; start = 1'b0;
    lif.DONE = 1'b0; lif.C1X = '0; lif.C1Y = '0; lif.C2X = '0; lif.C2Y = '0;
    test_reset();
    test_all_sevens();
    test_radius_boundary();
    test_stream_order();
    test_write_with_start();
    test_random();
    test_reset_midstream();
`ifdef LASER_HOST_TIMEOUT_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
